// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream frame generator slice.
package axis_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_CNT_WIDTH  = 16;
  localparam int STATE_W            = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/axis_beat_counter.sv
// Loadable down-counter with a registered terminal flag (count == 1).
// Loading zero parks the counter with the flag low.
module axis_beat_counter
  import axis_pkg::*;
#(
  parameter int Width = DEFAULT_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             dec,
  output logic             terminal
);

  logic [Width-1:0] count;

  // Load takes priority; the flag is computed from the value the count is about to hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      terminal <= 1'b0;
    end else if (load) begin
      count    <= load_value;
      terminal <= (load_value == Width'(1));
    end else if (dec && (count != '0)) begin
      count    <= count - Width'(1);
      terminal <= (count == Width'(2));
    end
  end

endmodule

// File: rtl/axis_frame_gen.sv
// AXI-Stream frame source: ramp data, m_last on the final beat, k idle
// cycles between frames, optional frame limit and graceful stop.
module axis_frame_gen
  import axis_pkg::*;
#(
  parameter int Data_width = DEFAULT_DATA_WIDTH,
  parameter int Cnt_width  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [Data_width-1:0] k,
  input  logic [Data_width-1:0] len,
  input  logic [Data_width-1:0] step,
  input  logic [Data_width-1:0] num_frames,
  output logic [Data_width-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [Cnt_width-1:0]  frame_cnt
);

  localparam int CMP_W = (Data_width > Cnt_width) ? Data_width : Cnt_width;

  state_t state, state_nxt;

  logic [Data_width-1:0] k_q, len_q, step_q, num_q;
  logic                  cfg_load;

  logic [Data_width-1:0] data_nxt;
  logic                  valid_nxt;
  logic [Cnt_width-1:0]  frame_nxt;
  logic [Cnt_width-1:0]  cnt_inc;
  logic                  stop_pend, stop_nxt;
  logic                  transfer;
  logic                  limit_hit;

  logic                  beat_load, beat_dec, beat_terminal;
  logic [Data_width-1:0] beat_value;
  logic                  gap_load, gap_dec, gap_terminal;
  logic [Data_width-1:0] gap_value;

  assign transfer  = m_valid && m_ready;
  assign cnt_inc   = frame_cnt + Cnt_width'(1);
  assign limit_hit = (num_q != '0) && (CMP_W'(cnt_inc) == CMP_W'(num_q));

  // m_last is the beat counter's registered terminal flag; the counter is
  // parked at zero outside SEND so the flag is low there.
  assign m_last = beat_terminal;

  axis_beat_counter #(.Width(Data_width)) u_beat (
    .clk        (clk),
    .rst        (rst),
    .load       (beat_load),
    .load_value (beat_value),
    .dec        (beat_dec),
    .terminal   (beat_terminal)
  );

  axis_beat_counter #(.Width(Data_width)) u_gap (
    .clk        (clk),
    .rst        (rst),
    .load       (gap_load),
    .load_value (gap_value),
    .dec        (gap_dec),
    .terminal   (gap_terminal)
  );

  // Configuration snapshot taken only when a start is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q    <= '0;
      len_q  <= '0;
      step_q <= '0;
      num_q  <= '0;
    end else if (cfg_load) begin
      k_q    <= k;
      len_q  <= len;
      step_q <= step;
      num_q  <= num_frames;
    end
  end

  // FSM and output registers; busy is registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_cnt <= '0;
      stop_pend <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      m_data    <= data_nxt;
      m_valid   <= valid_nxt;
      frame_cnt <= frame_nxt;
      stop_pend <= stop_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

  // Next-state, next-output and counter control.
  always_comb begin
    state_nxt  = state;
    data_nxt   = m_data;
    valid_nxt  = m_valid;
    frame_nxt  = frame_cnt;
    stop_nxt   = stop_pend;
    cfg_load   = 1'b0;
    beat_load  = 1'b0;
    beat_value = '0;
    beat_dec   = 1'b0;
    gap_load   = 1'b0;
    gap_value  = '0;
    gap_dec    = 1'b0;

    case (state)
      IDLE: begin
        stop_nxt = 1'b0;
        if (start && (len != '0)) begin
          cfg_load   = 1'b1;
          data_nxt   = '0;
          frame_nxt  = '0;
          valid_nxt  = 1'b1;
          beat_load  = 1'b1;
          beat_value = len;
          stop_nxt   = stop;
          state_nxt  = SEND;
        end
      end

      SEND: begin
        stop_nxt = stop_pend | stop;
        if (transfer) begin
          data_nxt = m_data + step_q;
          if (beat_terminal) begin
            frame_nxt = cnt_inc;
            if (stop_pend || limit_hit) begin
              state_nxt  = IDLE;
              valid_nxt  = 1'b0;
              stop_nxt   = 1'b0;
              beat_load  = 1'b1;
              beat_value = '0;
            end else if (k_q == '0) begin
              beat_load  = 1'b1;
              beat_value = len_q;
            end else begin
              state_nxt  = GAP;
              valid_nxt  = 1'b0;
              beat_load  = 1'b1;
              beat_value = '0;
              gap_load   = 1'b1;
              gap_value  = k_q;
            end
          end else begin
            beat_dec = 1'b1;
          end
        end
      end

      GAP: begin
        stop_nxt = stop_pend | stop;
        if (stop || stop_pend) begin
          state_nxt = IDLE;
          stop_nxt  = 1'b0;
          gap_load  = 1'b1;
          gap_value = '0;
        end else if (gap_terminal) begin
          state_nxt  = SEND;
          valid_nxt  = 1'b1;
          beat_load  = 1'b1;
          beat_value = len_q;
        end else begin
          gap_dec = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Self-checking bench for axis_frame_gen: expected beats are generated
// as a flat list from the frame/ramp rules and consumed on each handshake.
module tb_axis_frame_gen;

  localparam int DW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [DW-1:0] k;
  logic [DW-1:0] len;
  logic [DW-1:0] step;
  logic [DW-1:0] num_frames;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic          busy;
  logic [CW-1:0] frame_cnt;

  int tests    = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_frame_gen #(.Data_width(DW), .Cnt_width(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .k          (k),
    .len        (len),
    .step       (step),
    .num_frames (num_frames),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one start..IDLE episode. readyMode: 0 always ready, 1 pattern 1,0,0,
  // 2 random (also spams start to show it is ignored while busy).
  task automatic applyStimulus(input int lenV, input int kV, input int stepV, input int numV,
                               input int readyMode, input int stopAfter,
                               input bit stopWithStart, input int expFrames);
    logic [DW-1:0] expData[$];
    logic          expLast[$];
    logic [DW-1:0] heldData;
    logic          heldLast;
    logic          r;
    int            transfers = 0;
    int            lowCount  = 0;
    int            cycles    = 0;
    bit            inGap     = 0;
    bit            stalled   = 0;
    bit            stopDone  = 0;

    for (int f = 0; f < expFrames; f++) begin
      for (int b = 1; b <= lenV; b++) begin
        expData.push_back(DW'((f * lenV + b - 1) * stepV));
        expLast.push_back(b == lenV);
      end
    end

    @(negedge clk);
    k          = DW'(kV);
    len        = DW'(lenV);
    step       = DW'(stepV);
    num_frames = DW'(numV);
    start      = 1'b1;
    stop       = stopWithStart;
    m_ready    = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    stop       = 1'b0;
    k          = DW'($urandom);
    len        = DW'($urandom);
    step       = DW'($urandom);
    num_frames = DW'($urandom);
    checkOutput("first_valid_latency", 32'(m_valid), 32'd1);

    while (expData.size() > 0 && cycles < 3000) begin
      if (inGap) begin
        if (!m_valid) lowCount++;
        else begin
          checkOutput("gap_len", 32'(lowCount), 32'(kV));
          inGap = 0;
        end
      end
      if (stalled) begin
        checkOutput("stall_valid", 32'(m_valid), 32'd1);
        checkOutput("stall_data", 32'(m_data), 32'(heldData));
        checkOutput("stall_last", 32'(m_last), 32'(heldLast));
      end

      case (readyMode)
        0:       r = 1'b1;
        1:       r = ((cycles % 3) == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      m_ready = r;
      start   = (readyMode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      stop    = 1'b0;
      if (stopAfter >= 0 && !stopDone && transfers == stopAfter) begin
        stop     = 1'b1;
        stopDone = 1;
      end

      if (m_valid && r) begin
        checkOutput("beat_data", 32'(m_data), 32'(expData.pop_front()));
        checkOutput("beat_last", 32'(m_last), 32'(expLast.pop_front()));
        transfers++;
        if (m_last && expData.size() > 0) begin
          inGap    = 1;
          lowCount = 0;
        end
        stalled = 0;
      end else if (m_valid) begin
        stalled  = 1;
        heldData = m_data;
        heldLast = m_last;
      end else begin
        stalled = 0;
      end
      cycles++;
      @(negedge clk);
    end
    start   = 1'b0;
    stop    = 1'b0;
    m_ready = 1'b1;

    if (expData.size() != 0) checkOutput("timeout_beats_left", 32'(expData.size()), 32'd0);
    checkOutput("end_busy", 32'(busy), 32'd0);
    checkOutput("end_valid", 32'(m_valid), 32'd0);
    checkOutput("end_last", 32'(m_last), 32'd0);
    checkOutput("end_frame_cnt", 32'(frame_cnt), 32'(expFrames));
    @(negedge clk);
    checkOutput("stays_idle", 32'(m_valid), 32'd0);
  endtask

  initial begin
    int rl, rk, rs, rn;
    rst        = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    k          = '0;
    len        = '0;
    step       = '0;
    num_frames = '0;
    m_ready    = 1'b1;
    #1;
    checkOutput("reset_valid", 32'(m_valid), 32'd0);
    checkOutput("reset_data", 32'(m_data), 32'd0);
    checkOutput("reset_last", 32'(m_last), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // len==0 start must be ignored
    @(negedge clk);
    len   = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("len0_busy", 32'(busy), 32'd0);
    checkOutput("len0_valid", 32'(m_valid), 32'd0);

    // directed plan items
    applyStimulus(10, 4, 2, 2, 0, -1, 1'b0, 2);
    applyStimulus(3, 0, 1, 3, 0, -1, 1'b0, 3);
    applyStimulus(5, 2, 1, 1, 1, -1, 1'b0, 1);
    applyStimulus(6, 3, 1, 0, 0, 3, 1'b0, 1);
    applyStimulus(4, 1, 16'hFFFF, 1, 0, -1, 1'b0, 1);
    applyStimulus(1, 1, 7, 3, 1, -1, 1'b0, 3);
    applyStimulus(4, 2, 3, 0, 0, -1, 1'b1, 1);

    // asynchronous reset in the middle of a frame
    @(negedge clk);
    len        = 16'd8;
    step       = 16'd3;
    k          = 16'd1;
    num_frames = '0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midreset_valid", 32'(m_valid), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_data", 32'(m_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(3, 2, 5, 1, 0, -1, 1'b0, 1);

    // randomized episodes
    for (int i = 0; i < 4; i++) begin
      rl = $urandom_range(1, 6);
      rk = $urandom_range(0, 3);
      rs = $urandom_range(0, 65535);
      rn = $urandom_range(1, 3);
      applyStimulus(rl, rk, rs, rn, 2, -1, 1'b0, rn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/axis_frame_gen.md
Name: axis_frame_gen

Overview:
- AXI-Stream master-side frame source. It drives the slave port of the team's AXI-Stream frame FIFO.
- Emits frames of `len` beats with an arithmetic data ramp, asserts m_last on the final beat of each frame, and inserts `k` idle cycles between frames.
- Serves as the transmitter counterpart for FIFO bring-up and for on-chip traffic generation.

Parameters:
- Data_width, 16, width of the data path and of all configuration inputs.
- Cnt_width, 16, width of frame_cnt.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  one-cycle pulse; in IDLE, latches configuration and begins generation
- stop  input  1  request to finish the current frame, then return to IDLE
- k  input  Data_width  idle cycles inserted between frames
- len  input  Data_width  beats per frame
- step  input  Data_width  data increment per accepted beat
- num_frames  input  Data_width  frames to send; 0 = continuous
- m_data  output  Data_width  stream data
- m_valid  output  1  stream valid
- m_last  output  1  final beat of the frame
- m_ready  input  1  downstream ready
- busy  output  1  high whenever state != IDLE
- frame_cnt  output  Cnt_width  completed frames since the last start; wraps

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - m_data=0, m_valid=0, m_last=0, busy=0, frame_cnt=0.
  - beat, gap and stop_pend registers cleared.
- Handshake:
  - A beat transfers when m_valid && m_ready at the rising edge.
  - Once m_valid is high, m_valid, m_data and m_last hold stable until the transfer.
  - m_valid never depends combinationally on m_ready.
  - All outputs are registered.
- Configuration:
  - k, len, step and num_frames are latched on an accepted start.
  - Later input changes are ignored until the next return to IDLE.
  - start is ignored when len==0 or when not in IDLE.
- IDLE:
  - On start with len!=0: m_data=0, beat=1, frame_cnt=0, state goes to SEND.
  - m_valid rises on the cycle after start (1-cycle latency).
- SEND:
  - m_valid=1.
  - m_last=1 exactly when beat==len_latched.
  - On each transfer: m_data += step (mod 2^Data_width, wraps silently), beat += 1.
  - The ramp continues across frames; it is not reset per frame.
- End of frame (transfer with m_last=1):
  - frame_cnt += 1.
  - If stop_pend, or num_frames!=0 and frame_cnt+1==num_frames: go to IDLE.
  - Else if k==0: stay in SEND, beat=1, next frame starts with no bubble.
  - Else: go to GAP with gap=k, m_valid=0.
- GAP:
  - m_valid=0; gap decrements each cycle.
  - When gap==1: go to SEND, beat=1.
  - Result: exactly k cycles with m_valid low between the last beat and the next first beat.
- stop:
  - Sets stop_pend in any non-IDLE state.
  - In GAP, exits to IDLE immediately on the next edge.
  - In SEND, the current frame completes in full; no truncated frames are ever emitted.
  - stop and start in the same cycle while in IDLE: start wins; stop_pend is set, so exactly one frame is sent.
- len==1: every beat has m_last=1.
- Back-pressure: m_ready low for any duration stalls the beat and gap counters only while in SEND. GAP counts regardless of m_ready.
- Reset mid-frame: outputs drop to their reset values at once (asynchronous). No partial-frame recovery.

Decomposition:
- Shared package axis_pkg:
  - state encoding typedef (IDLE, SEND, GAP)
  - localparams for state widths
  - helper constant for the default Data_width
- One natural sub-module: axis_beat_counter, a loadable down-counter with a terminal flag, reused for both the beat and gap counts.
- The top level holds the FSM and the data ramp.

Test Plan:
- len=10, k=4, step=2, num_frames=2, m_ready=1:
  - data 0,2,…,18 with m_last on 18;
  - then exactly 4 idle cycles;
  - then data 20..38 with m_last on 38;
  - frame_cnt=2, busy falls.
- len=3, k=0, step=1, num_frames=3: 9 consecutive valid beats with data 0..8, m_last on 2, 5 and 8, and no bubbles.
- len=5, step=1, m_ready toggled 1,0,0,1,…: no beat lost or duplicated, m_data stable while stalled, data sequence 0..4.
- num_frames=0, stop pulsed mid-frame at beat 3 of len=6: the frame completes through beat 6 with m_last, then IDLE; no GAP.
- Data_width=16, step=16'hFFFF, len=4: data 0, FFFF, FFFE, FFFD (wrap).
- rst pulled low mid-frame: m_valid=0 asynchronously; after release plus start, the ramp restarts at 0.
